// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous RAM family: default geometry,
// clear-sequencer state encoding and address-width derivation.
package ram_pkg;

  localparam int RAM_WIDTH = 8;
  localparam int RAM_DEPTH = 1024;

  typedef enum logic [0:0] {
    CLR_SWEEP = 1'b0,
    CLR_DONE  = 1'b1
  } clr_state_e;

  // Ceiling log2, clamped to at least one bit so a 1-word RAM still has an address.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, zeroing it, and
// holds busy high until the last word has been written.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = addr_width(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  clr_state_e    state_r;
  clr_state_e    state_nxt_s;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_nxt_s;
  logic          busy_r;

  // State, pointer and busy flag registers; reset restarts the sweep at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLR_SWEEP;
      ptr_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= (state_nxt_s == CLR_SWEEP);
    end
  end

  // Next-state logic: advance one word per cycle, finish on the last address.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      CLR_SWEEP: begin
        ptr_nxt_s = ptr_r + ADDR_ONE;
        if (ptr_r == LAST_ADDR) begin
          state_nxt_s = CLR_DONE;
        end else begin
          state_nxt_s = CLR_SWEEP;
        end
      end
      CLR_DONE: begin
        state_nxt_s = CLR_DONE;
        ptr_nxt_s   = ptr_r;
      end
      default: begin
        state_nxt_s = CLR_SWEEP;
        ptr_nxt_s   = {AW{1'b0}};
      end
    endcase
  end

  assign busy     = busy_r;
  assign clr_addr = ptr_r;

endmodule

// File: rtl/ram_syn_1024x8.sv
// Single-port synchronous RAM with write-through registered read and a
// built-in post-reset clear sweep that makes contents deterministic.
module ram_syn_1024x8
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = addr_width(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    addr,
  input  logic             w_en,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] dout_r;
  logic             clr_busy_s;
  logic [AW-1:0]    clr_addr_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (clr_busy_s),
    .clr_addr (clr_addr_s)
  );

  // Write-port mux: the sweep owns the port while busy; the reset edge writes nothing.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = addr;
    wr_data_s = din;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (clr_busy_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_s;
      wr_data_s = {WIDTH{1'b0}};
    end else begin
      wr_en_s = w_en;
    end
  end

  // Storage array with a single synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Output register: zero during reset and sweep, write-through on writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {WIDTH{1'b0}};
    end else if (clr_busy_s) begin
      dout_r <= {WIDTH{1'b0}};
    end else if (w_en) begin
      dout_r <= din;
    end else begin
      dout_r <= mem_r[addr];
    end
  end

  assign dout = dout_r;
  assign busy = clr_busy_s;

endmodule

// File: tb/tb_ram_syn_1024x8.sv
// Self-checking bench for ram_syn_1024x8: directed table, clear/reset corner
// sequences and randomized traffic against a behavioural memory model.
module tb_ram_syn_1024x8;

  localparam int DEPTH = 1024;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [9:0] addr;
  logic       w_en;
  logic [7:0] dout;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: a plain array plus a count of words still to be cleared.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_dout;
  int         m_left;

  typedef struct {
    logic       we;
    logic [9:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [26];

  ram_syn_1024x8 dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .addr (addr),
    .w_en (w_en),
    .dout (dout),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model advances, then dout and busy are compared.
  task automatic step(input logic r, input logic we, input logic [9:0] a, input logic [7:0] d);
    rst  = r;
    w_en = we;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_dout = 8'd0;
      m_left = DEPTH;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 8'd0;
      m_left--;
      m_dout = 8'd0;
    end else if (we) begin
      m_mem[a] = d;
      m_dout   = d;
    end else begin
      m_dout = m_mem[a];
    end
    chk("dout_model", {24'd0, dout}, {24'd0, m_dout});
    chk("busy_model", {31'd0, busy}, {31'd0, (m_left > 0)});
  endtask

  // Run idle random traffic until busy drops; returns the number of busy cycles.
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'($urandom), 10'($urandom), 8'($urandom));
      cnt++;
      if (!busy) break;
    end
  endtask

  task automatic set_vec(input int i, input logic we, input int a, input int d, input int e);
    tbl[i].we  = we;
    tbl[i].a   = 10'(a);
    tbl[i].d   = 8'(d);
    tbl[i].exp = 8'(e);
  endtask

  initial begin
    int wa [10];
    int wd [10];
    int cnt;
    int big;

    wa = '{1010, 1000, 788, 888, 444, 977, 555, 666, 899, 1023};
    wd = '{210, 110, 158, 144, 220, 122, 10, 9, 108, 119};
    big = 256;
    for (int i = 0; i < 10; i++) begin
      set_vec(i,      1'b1, wa[i], wd[i], wd[i]);
      set_vec(i + 10, 1'b0, wa[i], 0,     wd[i]);
    end
    set_vec(20, 1'b1, 999,  big, 0);
    set_vec(21, 1'b0, 999,  0,   0);
    set_vec(22, 1'b0, 1000, 0,   110);
    set_vec(23, 1'b1, 5,    8'hA5, 8'hA5);
    set_vec(24, 1'b0, 5,    0,   8'hA5);
    set_vec(25, 1'b0, 6,    0,   0);

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hxx;
    m_dout = 8'hxx;
    m_left = 0;
    rst = 1'b1; w_en = 1'b0; addr = 10'd0; din = 8'd0;

    // Reset for two cycles, then the sweep must last exactly DEPTH cycles.
    step(1'b1, 1'b0, 10'd0, 8'd0);
    step(1'b1, 1'b0, 10'd0, 8'd0);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_dout", {24'd0, dout}, 32'd0);
    step(1'b0, 1'b1, 10'd3, 8'hFF);
    wait_sweep(cnt);
    chk("sweep_len", cnt + 1, DEPTH);
    step(1'b0, 1'b0, 10'd500, 8'd0);
    chk("read_500", {24'd0, dout}, 32'd0);
    step(1'b0, 1'b0, 10'd3, 8'd0);
    chk("busy_ignore_3", {24'd0, dout}, 32'd0);

    // Directed table: burst writes, readback, truncation, write-through.
    for (int i = 0; i < 26; i++) begin
      step(1'b0, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl_%0d", i), {24'd0, dout}, {24'd0, tbl[i].exp});
    end

    // Reset in the middle of a sweep restarts it and wipes earlier data.
    step(1'b0, 1'b1, 10'd1023, 8'h77);
    step(1'b1, 1'b0, 10'd0, 8'd0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 10'($urandom), 8'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0, 10'd0, 8'd0);
    wait_sweep(cnt);
    chk("restart_len", cnt, DEPTH);
    step(1'b0, 1'b0, 10'd1023, 8'd0);
    chk("restart_1023", {24'd0, dout}, 32'd0);

    // Random traffic, concentrated on a few addresses to hit read-after-write.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0)
        step(1'b0, 1'($urandom), 10'($urandom_range(0, 7)), 8'($urandom));
      else
        step(1'b0, 1'($urandom), 10'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_syn_1024x8.md
Name: ram_syn_1024x8

Overview:
- Single-port synchronous RAM, DEPTH×WIDTH (default 1024×8), with one address bus shared by read and write.
- Writes happen on the rising clock edge when w_en=1.
- Reads are registered, with 1-cycle latency.
- After reset, a built-in clear sequencer zeroes every location so contents are deterministic.
- General-purpose storage leaf for datapath and buffering blocks.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 1024, number of words; must be a power of two.
- AW, 10, address width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  write data.
- addr  input  AW  read/write address.
- w_en  input  1  1 = write din to addr; 0 = read addr.
- dout  output  WIDTH  registered read data.
- busy  output  1  high while the post-reset clear sweep runs; user accesses are ignored while high.

Behaviour:
- Everything is sampled on the rising edge of clk. There is no asynchronous logic.
- Reset (rst=1 at an edge):
  - dout <= 0, busy <= 1, clear pointer <= 0.
  - The memory array is not touched during the reset edge itself.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- Clear sweep (busy=1, rst=0):
  - Each edge: mem[ptr] <= 0, then ptr <= ptr+1.
  - When ptr = DEPTH-1 has been written, busy <= 0 on that same edge.
  - Duration is DEPTH cycles after reset deasserts.
  - din, addr and w_en are ignored; dout holds 0.
- Normal write (busy=0, w_en=1): mem[addr] <= din.
  - Write-through: dout <= din on the same edge, so write data is visible 1 cycle later.
- Normal read (busy=0, w_en=0): dout <= mem[addr], 1-cycle latency.
  - dout holds its value until the next access edge.
- Back-to-back operations: one access per cycle, no stalls.
  - A read at the edge after a write to the same address returns the new data.
- Width rules: din and addr are exactly WIDTH and AW bits; there is no wrap logic beyond the natural AW-bit range.
  - Address DEPTH-1 (1023) is fully usable.
- Power-up before the first reset: contents and dout are undefined (X in simulation). Benches must apply reset first.
- Implementation: inferable block RAM style, i.e. a single array with one synchronous write port and one registered read port. No byte enables.

Decomposition:
- Shared package ram_pkg holds:
  - default WIDTH/DEPTH localparams;
  - an AW derivation function (clog2).
- One sub-module is natural: ram_clear_seq.
  - Contains the sweep counter and busy flag.
  - Drives the internal write-address/data/enable mux select.
- The array and output register stay in the top module.

Test Plan:
1. Reset and clear: rst=1 for 2 cycles, then release.
   - busy=1 for exactly 1024 cycles, then 0; dout=0 throughout.
   - A read of any address (e.g. 500) afterwards returns 0.
2. Write burst then readback: write 210@1010, 110@1000, 158@788, 144@888, 220@444, 122@977, 10@555, 9@666, 108@899, 119@1023.
   - Reading the same addresses with w_en=0 returns each value 1 cycle after its read edge.
3. Truncated data: write din=0 (8-bit truncation of 256) @999.
   - Read 999 -> dout=0; neighbouring 1000 still reads 110.
4. Write-through and read-after-write: write 0xA5@5.
   - dout=0xA5 the next cycle.
   - An immediate read of addr 5 -> 0xA5; a read of addr 6 -> 0.
5. Ignore during busy: issue w_en=1, din=0xFF, addr=3 while busy=1.
   - After busy falls, read 3 -> 0.
6. Reset mid-sweep: assert rst at sweep cycle 300.
   - The sweep restarts: busy stays high for a further 1024 cycles after release.
   - Data written to 1023 before the reset reads 0 afterwards.
